// File: rtl/rv32_instr_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder: symbolic op codes,
// base opcodes, funct3/funct7 values, the canonical NOP and FSM states.
// Optional feature macro: RV32_ENC_NOP_PAD_EN (adds the PAD state).
package rv32_instr_encoder_pkg;

  // Symbolic operations presented on in_op
  localparam logic [5:0] ENC_LUI   = 6'd0;
  localparam logic [5:0] ENC_AUIPC = 6'd1;
  localparam logic [5:0] ENC_JAL   = 6'd2;
  localparam logic [5:0] ENC_JALR  = 6'd3;
  localparam logic [5:0] ENC_BEQ   = 6'd4;
  localparam logic [5:0] ENC_BNE   = 6'd5;
  localparam logic [5:0] ENC_BLT   = 6'd6;
  localparam logic [5:0] ENC_BGE   = 6'd7;
  localparam logic [5:0] ENC_BLTU  = 6'd8;
  localparam logic [5:0] ENC_BGEU  = 6'd9;
  localparam logic [5:0] ENC_LB    = 6'd10;
  localparam logic [5:0] ENC_LH    = 6'd11;
  localparam logic [5:0] ENC_LW    = 6'd12;
  localparam logic [5:0] ENC_LBU   = 6'd13;
  localparam logic [5:0] ENC_LHU   = 6'd14;
  localparam logic [5:0] ENC_SB    = 6'd15;
  localparam logic [5:0] ENC_SH    = 6'd16;
  localparam logic [5:0] ENC_SW    = 6'd17;
  localparam logic [5:0] ENC_ADDI  = 6'd18;
  localparam logic [5:0] ENC_SLTI  = 6'd19;
  localparam logic [5:0] ENC_SLTIU = 6'd20;
  localparam logic [5:0] ENC_XORI  = 6'd21;
  localparam logic [5:0] ENC_ORI   = 6'd22;
  localparam logic [5:0] ENC_ANDI  = 6'd23;
  localparam logic [5:0] ENC_SLLI  = 6'd24;
  localparam logic [5:0] ENC_SRLI  = 6'd25;
  localparam logic [5:0] ENC_SRAI  = 6'd26;
  localparam logic [5:0] ENC_ADD   = 6'd27;
  localparam logic [5:0] ENC_SUB   = 6'd28;
  localparam logic [5:0] ENC_SLL   = 6'd29;
  localparam logic [5:0] ENC_SLT   = 6'd30;
  localparam logic [5:0] ENC_SLTU  = 6'd31;
  localparam logic [5:0] ENC_XOR   = 6'd32;
  localparam logic [5:0] ENC_SRL   = 6'd33;
  localparam logic [5:0] ENC_SRA   = 6'd34;
  localparam logic [5:0] ENC_OR    = 6'd35;
  localparam logic [5:0] ENC_AND   = 6'd36;

  // Major opcodes (bits 6:0); OP_ADD is the register-register group
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_ADD    = 7'b0110011;

  // funct3 values, shared by groups that reuse the same code
  localparam logic [2:0] FUNCT3_BEQ  = 3'd0;
  localparam logic [2:0] FUNCT3_BNE  = 3'd1;
  localparam logic [2:0] FUNCT3_BLT  = 3'd4;
  localparam logic [2:0] FUNCT3_BGE  = 3'd5;
  localparam logic [2:0] FUNCT3_BLTU = 3'd6;
  localparam logic [2:0] FUNCT3_BGEU = 3'd7;
  localparam logic [2:0] FUNCT3_B    = 3'd0;  // LB / SB
  localparam logic [2:0] FUNCT3_H    = 3'd1;  // LH / SH
  localparam logic [2:0] FUNCT3_W    = 3'd2;  // LW / SW
  localparam logic [2:0] FUNCT3_BU   = 3'd4;
  localparam logic [2:0] FUNCT3_HU   = 3'd5;
  localparam logic [2:0] FUNCT3_ADD  = 3'd0;  // ADD/SUB/ADDI/JALR
  localparam logic [2:0] FUNCT3_SLL  = 3'd1;
  localparam logic [2:0] FUNCT3_SLT  = 3'd2;
  localparam logic [2:0] FUNCT3_SLTU = 3'd3;
  localparam logic [2:0] FUNCT3_XOR  = 3'd4;
  localparam logic [2:0] FUNCT3_SR   = 3'd5;  // SRL/SRA and immediate forms
  localparam logic [2:0] FUNCT3_OR   = 3'd6;
  localparam logic [2:0] FUNCT3_AND  = 3'd7;

  localparam logic [6:0] FUNCT7_BASE = 7'h00;
  localparam logic [6:0] FUNCT7_ALT  = 7'h20;  // SUB / SRA / SRAI

  localparam logic [31:0] NOP = 32'h0000_0013;  // addi x0, x0, 0

  // Instruction layouts understood by the packer
  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J
  } fmt_e;

  // Session FSM states
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ENCODE,
    ST_DONE
`ifdef RV32_ENC_NOP_PAD_EN
    , ST_PAD
`endif
  } state_e;

endpackage

// File: rtl/rv32_instr_pack.sv
// Combinational packer: symbolic op + register indices + immediate ->
// 32-bit RV32I word. Unknown ops produce the canonical NOP and flag illegal.
module rv32_instr_pack
  import rv32_instr_encoder_pkg::*;
(
  input  logic [5:0]  op_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  fmt_e       fmt;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  // Decode the symbolic op into layout, opcode and function fields
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    fmt       = FMT_I;
    opcode    = OP_IMM;
    funct3    = FUNCT3_ADD;
    funct7    = FUNCT7_BASE;
    illegal_o = 1'b0;
    case (op_i)
      ENC_LUI:   begin fmt = FMT_U; opcode = OP_LUI;   end
      ENC_AUIPC: begin fmt = FMT_U; opcode = OP_AUIPC; end
      ENC_JAL:   begin fmt = FMT_J; opcode = OP_JAL;   end
      ENC_JALR:  begin fmt = FMT_I; opcode = OP_JALR; funct3 = FUNCT3_ADD; end
      ENC_BEQ:   begin fmt = FMT_B; opcode = OP_BRANCH; funct3 = FUNCT3_BEQ;  end
      ENC_BNE:   begin fmt = FMT_B; opcode = OP_BRANCH; funct3 = FUNCT3_BNE;  end
      ENC_BLT:   begin fmt = FMT_B; opcode = OP_BRANCH; funct3 = FUNCT3_BLT;  end
      ENC_BGE:   begin fmt = FMT_B; opcode = OP_BRANCH; funct3 = FUNCT3_BGE;  end
      ENC_BLTU:  begin fmt = FMT_B; opcode = OP_BRANCH; funct3 = FUNCT3_BLTU; end
      ENC_BGEU:  begin fmt = FMT_B; opcode = OP_BRANCH; funct3 = FUNCT3_BGEU; end
      ENC_LB:    begin fmt = FMT_I; opcode = OP_LOAD; funct3 = FUNCT3_B;  end
      ENC_LH:    begin fmt = FMT_I; opcode = OP_LOAD; funct3 = FUNCT3_H;  end
      ENC_LW:    begin fmt = FMT_I; opcode = OP_LOAD; funct3 = FUNCT3_W;  end
      ENC_LBU:   begin fmt = FMT_I; opcode = OP_LOAD; funct3 = FUNCT3_BU; end
      ENC_LHU:   begin fmt = FMT_I; opcode = OP_LOAD; funct3 = FUNCT3_HU; end
      ENC_SB:    begin fmt = FMT_S; opcode = OP_STORE; funct3 = FUNCT3_B; end
      ENC_SH:    begin fmt = FMT_S; opcode = OP_STORE; funct3 = FUNCT3_H; end
      ENC_SW:    begin fmt = FMT_S; opcode = OP_STORE; funct3 = FUNCT3_W; end
      ENC_ADDI:  begin fmt = FMT_I;  funct3 = FUNCT3_ADD;  end
      ENC_SLTI:  begin fmt = FMT_I;  funct3 = FUNCT3_SLT;  end
      ENC_SLTIU: begin fmt = FMT_I;  funct3 = FUNCT3_SLTU; end
      ENC_XORI:  begin fmt = FMT_I;  funct3 = FUNCT3_XOR;  end
      ENC_ORI:   begin fmt = FMT_I;  funct3 = FUNCT3_OR;   end
      ENC_ANDI:  begin fmt = FMT_I;  funct3 = FUNCT3_AND;  end
      ENC_SLLI:  begin fmt = FMT_SH; funct3 = FUNCT3_SLL;  end
      ENC_SRLI:  begin fmt = FMT_SH; funct3 = FUNCT3_SR;   end
      ENC_SRAI:  begin fmt = FMT_SH; funct3 = FUNCT3_SR; funct7 = FUNCT7_ALT; end
      ENC_ADD:   begin fmt = FMT_R; opcode = OP_ADD; funct3 = FUNCT3_ADD;  end
      ENC_SUB:   begin fmt = FMT_R; opcode = OP_ADD; funct3 = FUNCT3_ADD; funct7 = FUNCT7_ALT; end
      ENC_SLL:   begin fmt = FMT_R; opcode = OP_ADD; funct3 = FUNCT3_SLL;  end
      ENC_SLT:   begin fmt = FMT_R; opcode = OP_ADD; funct3 = FUNCT3_SLT;  end
      ENC_SLTU:  begin fmt = FMT_R; opcode = OP_ADD; funct3 = FUNCT3_SLTU; end
      ENC_XOR:   begin fmt = FMT_R; opcode = OP_ADD; funct3 = FUNCT3_XOR;  end
      ENC_SRL:   begin fmt = FMT_R; opcode = OP_ADD; funct3 = FUNCT3_SR;   end
      ENC_SRA:   begin fmt = FMT_R; opcode = OP_ADD; funct3 = FUNCT3_SR; funct7 = FUNCT7_ALT; end
      ENC_OR:    begin fmt = FMT_R; opcode = OP_ADD; funct3 = FUNCT3_OR;   end
      ENC_AND:   begin fmt = FMT_R; opcode = OP_ADD; funct3 = FUNCT3_AND;  end
      default:   illegal_o = 1'b1;
    endcase
  end

  // Assemble the word; register fields a layout does not use stay zero
  always_comb begin
    word_o = NOP;
    case (fmt)
      FMT_R:  word_o = {funct7, rs2_i, rs1_i, funct3, rd_i, opcode};
      FMT_I:  word_o = {imm_i[11:0], rs1_i, funct3, rd_i, opcode};
      FMT_SH: word_o = {funct7, imm_i[4:0], rs1_i, funct3, rd_i, opcode};
      FMT_S:  word_o = {imm_i[11:5], rs2_i, rs1_i, funct3, imm_i[4:0], opcode};
      FMT_B:  word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3,
                        imm_i[4:1], imm_i[11], opcode};
      FMT_U:  word_o = {imm_i[31:12], rd_i, opcode};
      FMT_J:  word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode};
      default: word_o = NOP;
    endcase
    if (illegal_o) word_o = NOP;
  end

endmodule

// File: rtl/rv32_instr_encoder.sv
// Session-based RV32I encoder: accepts symbolic ops over valid/ready, packs
// them and writes one word per accepted op into IMEM, one cycle later.
// Optional feature macro: RV32_ENC_NOP_PAD_EN (NOP-pads sessions to 4 words).
module rv32_instr_encoder
  import rv32_instr_encoder_pkg::*;
#(
  parameter int          ADDR_WIDTH = 8,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [5:0]            in_op,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [31:0]           in_imm,
  input  logic                  in_last,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  err_illegal,
  output logic                  err_overflow
);

  localparam logic [ADDR_WIDTH-1:0] BASE    = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] A_ONE   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   C_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   CAP     = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;          // address of the next write
  logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;  // address of the current write
  logic [31:0]           imem_wdata_q, imem_wdata_d;
  logic                  imem_we_q, imem_we_d;
  logic                  in_ready_q, in_ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  err_illegal_q, err_illegal_d;
  logic                  err_overflow_q, err_overflow_d;

  logic [31:0]           pack_word;
  logic                  pack_illegal;
  logic                  accept;
  logic [ADDR_WIDTH:0]   count_inc;

  rv32_instr_pack u_pack (
    .op_i      (in_op),
    .rd_i      (in_rd),
    .rs1_i     (in_rs1),
    .rs2_i     (in_rs2),
    .imm_i     (in_imm),
    .word_o    (pack_word),
    .illegal_o (pack_illegal)
  );

`ifdef RV32_ENC_NOP_PAD_EN
  // Padding continues while the count is unaligned and capacity remains
  function automatic logic pad_needed(input logic [ADDR_WIDTH:0] c);
    return (c[1:0] != 2'b00) && (c != CAP);
  endfunction
`endif

  // in_ready is only ever high in ENCODE, so it doubles as the state qualifier
  assign accept    = in_valid && in_ready_q;
  assign count_inc = (count_q == CAP) ? CAP : count_q + C_ONE;

  // Next-state and next-output computation for the session FSM
  always_comb begin
    state_d        = state_q;
    waddr_d        = waddr_q;
    imem_addr_d    = imem_addr_q;
    imem_wdata_d   = imem_wdata_q;
    imem_we_d      = 1'b0;
    count_d        = count_q;
    err_illegal_d  = err_illegal_q;
    err_overflow_d = err_overflow_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d        = ST_ENCODE;
          waddr_d        = BASE;
          imem_addr_d    = BASE;
          count_d        = '0;
          err_illegal_d  = 1'b0;
          err_overflow_d = 1'b0;
        end
      end
      ST_ENCODE: begin
        if (accept) begin
          imem_we_d     = 1'b1;
          imem_addr_d   = waddr_q;
          imem_wdata_d  = pack_word;
          waddr_d       = waddr_q + A_ONE;
          count_d       = count_inc;
          err_illegal_d = err_illegal_q | pack_illegal;
          if (in_last) begin
`ifdef RV32_ENC_NOP_PAD_EN
            state_d = pad_needed(count_inc) ? ST_PAD : ST_DONE;
`else
            state_d = ST_DONE;
`endif
          end
        end else if (in_valid && (count_q == CAP)) begin
          // Capacity reached without a last marker: drop the op and stop
          err_overflow_d = 1'b1;
          state_d        = ST_DONE;
        end
      end
`ifdef RV32_ENC_NOP_PAD_EN
      ST_PAD: begin
        imem_we_d    = 1'b1;
        imem_addr_d  = waddr_q;
        imem_wdata_d = NOP;
        waddr_d      = waddr_q + A_ONE;
        count_d      = count_inc;
        if (!pad_needed(count_inc)) state_d = ST_DONE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    in_ready_d = (state_d == ST_ENCODE) && (count_d != CAP);
    busy_d     = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d     = (state_d == ST_DONE);
  end

  // State and registered outputs, synchronous active-high reset
  always_ff @(posedge clk) begin
    // NOTE: clocked state is assigned only with <= so all registers update together.
    if (reset) begin
      state_q        <= ST_IDLE;
      waddr_q        <= BASE;
      imem_addr_q    <= BASE;
      imem_wdata_q   <= '0;
      imem_we_q      <= 1'b0;
      in_ready_q     <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      count_q        <= '0;
      err_illegal_q  <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      waddr_q        <= waddr_d;
      imem_addr_q    <= imem_addr_d;
      imem_wdata_q   <= imem_wdata_d;
      imem_we_q      <= imem_we_d;
      in_ready_q     <= in_ready_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      count_q        <= count_d;
      err_illegal_q  <= err_illegal_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  // A reset arriving while a write is on the port suppresses that write
  assign imem_we      = imem_we_q && !reset;
  assign imem_addr    = imem_addr_q;
  assign imem_wdata   = imem_wdata_q;
  assign in_ready     = in_ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign count        = count_q;
  assign err_illegal  = err_illegal_q;
  assign err_overflow = err_overflow_q;

endmodule

// File: doc/rv32_instr_encoder.md
Name: rv32_instr_encoder

Overview:
- Inverse of the ID-stage controller: takes symbolic RV32I operations (op enum plus rd/rs1/rs2/imm) over a valid/ready stream and encodes them into 32-bit instruction words.
- Writes the encoded words sequentially into instruction memory through a word-addressed write port.
- Used by the test infrastructure and the boot loader to build programs in IMEM without an external assembler.
- Contains a session FSM, a write-address counter, a one-stage encode pipeline and sticky error flags.

Parameters:
- ADDR_WIDTH, 8, IMEM word-address width; capacity is 2^ADDR_WIDTH words.
- BASE_ADDR, 0, first word address written after start.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; begins a session, honoured only in IDLE or DONE
- in_valid  in  1  operation valid
- in_ready  out  1  encoder can accept an operation
- in_op  in  6  operation enum, shared package
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_imm  in  32  immediate, byte offset for branches and jumps
- in_last  in  1  marks the final operation of the session
- imem_we  out  1  IMEM write strobe
- imem_addr  out  ADDR_WIDTH  IMEM word address
- imem_wdata  out  32  encoded instruction
- busy  out  1  high while not in IDLE or DONE
- done  out  1  high while in DONE
- count  out  ADDR_WIDTH+1  words written in this session
- err_illegal  out  1  sticky: an illegal op was received
- err_overflow  out  1  sticky: IMEM capacity was exceeded

Behaviour:
- Clock is clk. Reset is synchronous and active-high.
- Reset values: state=IDLE, in_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, count=0, busy=0, done=0, err_*=0.
- States:
  - IDLE: start → ENCODE; address reloads to BASE_ADDR; count and err_* clear.
  - ENCODE: in_ready=1 unless count has reached 2^ADDR_WIDTH.
  - Accepted last op → DONE, or PAD when NOP_PAD_EN is defined.
  - DONE: start → ENCODE with the same clears as in IDLE.
- Transfer happens when in_valid && in_ready. Fields are sampled on that edge.
- Latency: imem_we=1 exactly one cycle after acceptance, with that op's addr and wdata. Back-to-back acceptance gives one write per cycle.
- After each write, imem_addr increments by 1 and wraps modulo 2^ADDR_WIDTH; count increments and saturates.
- Overflow:
  - Once count reaches 2^ADDR_WIDTH, in_ready=0.
  - If in_valid is still asserted without a prior last, set err_overflow and go to DONE; that op is not written.
- Op enum:
  - 0 LUI, 1 AUIPC, 2 JAL, 3 JALR
  - 4–9 BEQ, BNE, BLT, BGE, BLTU, BGEU
  - 10–14 LB, LH, LW, LBU, LHU
  - 15–17 SB, SH, SW
  - 18–26 ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI
  - 27–36 ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND
- Immediate formats:
  - I: imm[11:0].
  - Shift ops: imm[4:0] in bits 24:20; funct7 is 0x20 for SRAI and 0x00 otherwise.
  - S: imm[11:5] in bits 31:25, imm[4:0] in bits 11:7.
  - B: imm[12|10:5] in bits 31:25, imm[4:1|11] in bits 11:7.
  - U: imm[31:12].
  - J: imm[20|10:1|11|19:12].
  - Upper imm bits outside each format are ignored.
  - Unused register fields are zero: rs2 for I/U/J, rd for S/B.
- Illegal ops (37–63): write NOP 0x00000013, set err_illegal, count normally.
- start while busy is ignored.
- Reset mid-session aborts immediately; any pending write is dropped.

Optional Feature:
- Macro: RV32_ENC_NOP_PAD_EN.
- Defined:
  - After the last op, enter state PAD.
  - Write NOP 0x00000013 each cycle with in_ready=0 until count is a multiple of 4, then go to DONE.
  - If already aligned, go straight to DONE.
  - Padding stops at capacity without setting err_overflow.
- Undefined: the PAD state does not exist; last → DONE.

Decomposition:
- Shared package holds:
  - op enum localparams
  - opcode constants (OP_LUI … OP_ADD)
  - FUNCT3_* and FUNCT7_* values
  - NOP constant
  - state encodings
- Sub-module rv32_instr_pack: purely combinational (op, rd, rs1, rs2, imm) → (word, illegal). The top level keeps the FSM, counters and output register.

Test Plan:
- start, then ADDI rd=1 rs1=0 imm=5 with last → cycle+1: imem_we=1, addr 0, wdata 0x00500093; done=1, count=1.
- Stream without gaps:
  - LUI rd=2 imm=0x12345000 → 0x12345137
  - BEQ rs1=1 rs2=2 imm=8 → 0x00208463
  - SW rs1=1 rs2=2 imm=12 → 0x0020A623
  - SUB rd=3 rs1=1 rs2=2 → 0x402081B3
  - SRAI rd=4 rs1=1 imm=3 → 0x4030D213
  - JAL rd=1 imm=16 → 0x010000EF
  - Required: addresses 0..5 consecutive, one write per cycle.
- in_op=50 → wdata 0x00000013, err_illegal=1; it stays 1 until the next start.
- ADDR_WIDTH=2, 5 ops without last → 4 writes, then in_ready=0, err_overflow=1, done=1, count=4.
- Reset asserted one cycle after acceptance → no write; outputs at reset values next cycle.
- With RV32_ENC_NOP_PAD_EN defined: 3 ops, last on the third → one NOP at addr 3, count=4, in_ready=0 during PAD.
